mdu_hilo: RTL



---
 rtl/mdu_hilo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers (mult, multu, div, divu, mthi, mtlo).
// Define MDU_DIV_EN to build the restoring divider; without it div/divu complete immediately as no-ops.
module mdu_hilo (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_data_A,
  input  logic [31:0] i_data_B,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opb;
  logic        neg_p;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  logic        idle_like;
  logic        op_signed;
  logic        div_zero_nx;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [63:0] prod_fix;

`ifdef MDU_DIV_EN
  logic        is_div;
  logic        neg_r;
  logic [32:0] rem;
  logic [33:0] trial;
  logic        ge;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
`endif

  always_comb begin
    idle_like = (state == IDLE) || (state == DONE);
    op_signed = ~i_op[0];
    a_mag     = (op_signed && i_data_A[31]) ? -i_data_A : i_data_A;
    b_mag     = (op_signed && i_data_B[31]) ? -i_data_B : i_data_B;
  end

  // Multiply step: acc = {partial product high, remaining multiplier bits}.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mul_nx   = {mul_sum, acc[31:1]};
    prod_fix = neg_p ? -acc : acc;
  end

`ifdef MDU_DIV_EN
  // Divide step: acc[31:0] shifts dividend bits out and quotient bits in.
  always_comb begin
    trial  = {rem, acc[31]};
    ge     = (trial >= {2'b00, opb});
    rem_nx = ge ? 33'(trial - {2'b00, opb}) : trial[32:0];
    quo_nx = {acc[30:0], ge};
  end
`endif

  always_comb begin
    state_nx    = state;
    div_zero_nx = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (i_start) begin
          if (!i_op[1]) begin
            state_nx = CALC;
          end
`ifdef MDU_DIV_EN
          else if (i_data_B == '0) begin
            state_nx    = DONE;
            div_zero_nx = 1'b1;
          end else begin
            state_nx = CALC;
          end
`else
          else begin
            state_nx = DONE;
          end
`endif
        end
      end
      CALC:    if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      neg_p    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      rem      <= '0;
`endif
    end else begin
      busy     <= (state_nx == CALC) || (state_nx == FIX);
      done     <= (state_nx == DONE);
      div_zero <= div_zero_nx;

      if (idle_like) begin
        if (i_mthi) hi <= i_data_A;
        if (i_mtlo) lo <= i_data_A;
        // Operands are captured as magnitudes; signs are reapplied in FIX.
        if (state_nx == CALC) begin
          cnt   <= '0;
          neg_p <= op_signed & (i_data_A[31] ^ i_data_B[31]);
`ifdef MDU_DIV_EN
          is_div <= i_op[1];
          neg_r  <= op_signed & i_data_A[31];
          rem    <= '0;
          if (i_op[1]) begin
            acc <= {32'd0, a_mag};
            opb <= b_mag;
          end else begin
            acc <= {32'd0, b_mag};
            opb <= a_mag;
          end
`else
          acc <= {32'd0, b_mag};
          opb <= a_mag;
`endif
        end
      end

      if (state == CALC) begin
        cnt <= cnt + 5'd1;
`ifdef MDU_DIV_EN
        if (is_div) begin
          rem        <= rem_nx;
          acc[31:0]  <= quo_nx;
        end else
`endif
        acc <= mul_nx;
      end

      if (state == FIX) begin
`ifdef MDU_DIV_EN
        if (is_div) begin
          lo <= neg_p ? -acc[31:0] : acc[31:0];
          hi <= neg_r ? -rem[31:0] : rem[31:0];
        end else
`endif
        begin
          hi <= prod_fix[63:32];
          lo <= prod_fix[31:0];
        end
      end
    end
  end

  assign o_hi       = hi;
  assign o_lo       = lo;
  assign o_busy     = busy;
  assign o_done     = done;
  assign o_div_zero = div_zero;

endmodule
